// File: rtl/dtw_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dtw_seq_ctrl
// Sequencer for the DTW accelerator datapath, running in the AXIS clock domain.
// On a start strobe it steers input stream beats first into the reference
// memory (i_ref_len samples) and then into the DTW core (i_qry_len samples).
// It then waits for the core score and returns it as one AXIS result beat.
//
// Ports
//   i_axis_clk, i_axis_rst      clock, asynchronous active-low reset
//   i_start, i_abort            1-cycle control strobes
//   i_ref_len, i_qry_len        sample counts (ref_len 0 = reuse reference)
//   i_s_*, o_s_tready           input AXIS stream
//   o_ref_we/addr/wdata         reference memory write port (1-cycle latency)
//   o_core_start                1-cycle core start pulse
//   o_core_valid/data, i_core_ready   query sample stream to the core
//   i_core_done, i_core_score   core result strobe and score
//   o_m_*, i_m_tready           result AXIS stream (single beat)
//   o_busy, o_done, o_err       status (done/err sticky until accepted start)
//   o_ref_valid                 a complete reference is held in memory
//   o_cycle_cnt                 busy-cycle counter since the accepted start
//
// Configuration
//   DTW_SEQ_CYCLE_CNT_EN  when defined, o_cycle_cnt counts busy cycles from the
//                         accepted start (saturating); otherwise it is tied 0.
// -----------------------------------------------------------------------------
module dtw_seq_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int SCORE_W = 32
) (
    input  logic              i_axis_clk,
    input  logic              i_axis_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_ref_len,
    input  logic [ADDR_W-1:0] i_qry_len,
    input  logic              i_s_tvalid,
    output logic              o_s_tready,
    input  logic              i_s_tlast,
    input  logic [DATA_W-1:0] i_s_tdata,
    output logic              o_ref_we,
    output logic [ADDR_W-1:0] o_ref_addr,
    output logic [DATA_W-1:0] o_ref_wdata,
    output logic              o_core_start,
    output logic              o_core_valid,
    input  logic              i_core_ready,
    output logic [DATA_W-1:0] o_core_data,
    input  logic              i_core_done,
    input  logic [SCORE_W-1:0] i_core_score,
    output logic              o_m_tvalid,
    input  logic              i_m_tready,
    output logic              o_m_tlast,
    output logic [31:0]       o_m_tdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_ref_valid,
    output logic [31:0]       o_cycle_cnt
);

    localparam logic [ADDR_W-1:0] ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_REF  = 3'd1,
        ST_QUERY     = 3'd2,
        ST_WAIT_CORE = 3'd3,
        ST_RESULT    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] ref_len_q, ref_len_d;
    logic [ADDR_W-1:0] qry_len_q, qry_len_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ref_valid_q, ref_valid_d;
    logic [31:0]       score_q, score_d;
    logic              ld_rdy_q, ld_rdy_d;
    logic              ref_we_q, ref_we_d;
    logic [ADDR_W-1:0] ref_addr_q, ref_addr_d;
    logic [DATA_W-1:0] ref_wdata_q, ref_wdata_d;
    logic              core_start_q, core_start_d;

    logic start_ok_s;
    logic start_acc_s;
    logic beat_ld_s;
    logic beat_qy_s;

    // Start qualification and stream handshakes for the current state.
    always_comb begin
        start_ok_s  = (i_qry_len != ZERO) && ((i_ref_len != ZERO) || ref_valid_q);
        start_acc_s = (state_q == ST_IDLE) && i_start && !i_abort && start_ok_s;
        beat_ld_s   = (state_q == ST_LOAD_REF) && i_s_tvalid && ld_rdy_q;
        beat_qy_s   = (state_q == ST_QUERY) && i_s_tvalid && i_core_ready;
    end

    // Next-state and next-register computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ref_len_d    = ref_len_q;
        qry_len_d    = qry_len_q;
        done_d       = done_q;
        err_d        = err_q;
        ref_valid_d  = ref_valid_q;
        score_d      = score_q;
        ref_we_d     = 1'b0;
        ref_addr_d   = ref_addr_q;
        ref_wdata_d  = ref_wdata_q;
        core_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_acc_s) begin
                    ref_len_d = i_ref_len;
                    qry_len_d = i_qry_len;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cnt_d     = ZERO;
                    if (i_ref_len != ZERO) begin
                        state_d     = ST_LOAD_REF;
                        ref_valid_d = 1'b0;
                    end else begin
                        state_d      = ST_QUERY;
                        core_start_d = 1'b1;
                    end
                end else if (i_start && !i_abort) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_REF: begin
                if (beat_ld_s) begin
                    ref_we_d    = 1'b1;
                    ref_addr_d  = cnt_q;
                    ref_wdata_d = i_s_tdata;
                    cnt_d       = cnt_q + ONE;
                    if (cnt_q == (ref_len_q - ONE)) begin
                        if (i_s_tlast) begin
                            ref_valid_d  = 1'b1;
                            cnt_d        = ZERO;
                            core_start_d = 1'b1;
                            state_d      = ST_QUERY;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (i_s_tlast) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD_REF;
                    end
                end else begin
                    state_d = ST_LOAD_REF;
                end
            end
            ST_QUERY: begin
                if (beat_qy_s) begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == (qry_len_q - ONE)) begin
                        if (i_s_tlast) begin
                            cnt_d   = ZERO;
                            state_d = ST_WAIT_CORE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (i_s_tlast) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_QUERY;
                    end
                end else begin
                    state_d = ST_QUERY;
                end
            end
            ST_WAIT_CORE: begin
                if (i_core_done) begin
                    score_d = 32'(i_core_score);
                    state_d = ST_RESULT;
                end else begin
                    state_d = ST_WAIT_CORE;
                end
            end
            ST_RESULT: begin
                if (i_m_tready) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything decided above: no write, no pulse, no
        // status change, and a partially loaded reference stays invalid.
        if (i_abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            cnt_d        = cnt_q;
            done_d       = done_q;
            err_d        = err_q;
            score_d      = score_q;
            ref_we_d     = 1'b0;
            ref_addr_d   = ref_addr_q;
            ref_wdata_d  = ref_wdata_q;
            core_start_d = 1'b0;
            ref_valid_d  = (state_q == ST_LOAD_REF) ? 1'b0 : ref_valid_q;
        end else begin
            state_d = state_d;
        end

        // Input ready during reference load is a flop so it appears exactly
        // one cycle after the accepted start.
        ld_rdy_d = (state_d == ST_LOAD_REF);
    end

    // State and datapath registers.
    always_ff @(posedge i_axis_clk or negedge i_axis_rst) begin
        if (!i_axis_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= ZERO;
            ref_len_q    <= ZERO;
            qry_len_q    <= ZERO;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ref_valid_q  <= 1'b0;
            score_q      <= 32'h0;
            ld_rdy_q     <= 1'b0;
            ref_we_q     <= 1'b0;
            ref_addr_q   <= ZERO;
            ref_wdata_q  <= {DATA_W{1'b0}};
            core_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ref_len_q    <= ref_len_d;
            qry_len_q    <= qry_len_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ref_valid_q  <= ref_valid_d;
            score_q      <= score_d;
            ld_rdy_q     <= ld_rdy_d;
            ref_we_q     <= ref_we_d;
            ref_addr_q   <= ref_addr_d;
            ref_wdata_q  <= ref_wdata_d;
            core_start_q <= core_start_d;
        end
    end

`ifdef DTW_SEQ_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Busy-cycle counter: cleared on accepted start, saturates, holds in IDLE.
    always_comb begin
        cyc_d = cyc_q;
        if (start_acc_s) begin
            cyc_d = 32'h0;
        end else if ((state_q != ST_IDLE) && (cyc_q != 32'hFFFF_FFFF)) begin
            cyc_d = cyc_q + 32'd1;
        end else begin
            cyc_d = cyc_q;
        end
    end

    // Cycle counter register.
    always_ff @(posedge i_axis_clk or negedge i_axis_rst) begin
        if (!i_axis_rst) begin
            cyc_q <= 32'h0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign o_cycle_cnt = cyc_q;
`else
    assign o_cycle_cnt = 32'h0;
`endif

    // Query samples pass straight through to the core; everything else is
    // taken from registers.
    assign o_s_tready   = (state_q == ST_QUERY) ? i_core_ready : ld_rdy_q;
    assign o_core_valid = (state_q == ST_QUERY) && i_s_tvalid;
    assign o_core_data  = (state_q == ST_QUERY) ? i_s_tdata : {DATA_W{1'b0}};
    assign o_ref_we     = ref_we_q;
    assign o_ref_addr   = ref_addr_q;
    assign o_ref_wdata  = ref_wdata_q;
    assign o_core_start = core_start_q;
    assign o_m_tvalid   = (state_q == ST_RESULT);
    assign o_m_tlast    = (state_q == ST_RESULT);
    assign o_m_tdata    = score_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_ref_valid  = ref_valid_q;

endmodule

// File: tb/tb_dtw_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dtw_seq_ctrl
// Directed self-checking bench for dtw_seq_ctrl. Inputs change 1 time unit
// after the rising edge; outputs are checked at the same point, so registered
// outputs reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_dtw_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start, abort;
    logic [15:0] ref_len, qry_len;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic        ref_we;
    logic [15:0] ref_addr;
    logic [31:0] ref_wdata;
    logic        core_start, core_valid, core_ready;
    logic [31:0] core_data;
    logic        core_done;
    logic [31:0] core_score;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic        busy, done, err, ref_valid;
    logic [31:0] cycle_cnt;

    int checks;
    int errors;

    // Monitor records (written only by the monitor process).
    logic [15:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] core_q[$];
    int          core_start_cnt;

    int base_wr;
    int base_core;
    int base_cs;

    dtw_seq_ctrl #(.DATA_W(32), .ADDR_W(16), .SCORE_W(32)) dut (
        .i_axis_clk   (clk),
        .i_axis_rst   (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_ref_len    (ref_len),
        .i_qry_len    (qry_len),
        .i_s_tvalid   (s_tvalid),
        .o_s_tready   (s_tready),
        .i_s_tlast    (s_tlast),
        .i_s_tdata    (s_tdata),
        .o_ref_we     (ref_we),
        .o_ref_addr   (ref_addr),
        .o_ref_wdata  (ref_wdata),
        .o_core_start (core_start),
        .o_core_valid (core_valid),
        .i_core_ready (core_ready),
        .o_core_data  (core_data),
        .i_core_done  (core_done),
        .i_core_score (core_score),
        .o_m_tvalid   (m_tvalid),
        .i_m_tready   (m_tready),
        .o_m_tlast    (m_tlast),
        .o_m_tdata    (m_tdata),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_ref_valid  (ref_valid),
        .o_cycle_cnt  (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records reference writes, core start pulses and core handshakes.
    initial core_start_cnt = 0;
    always @(posedge clk) begin
        if (ref_we) begin
            wr_addr_q.push_back(ref_addr);
            wr_data_q.push_back(ref_wdata);
        end
        if (core_start) core_start_cnt = core_start_cnt + 1;
        if (core_valid && s_tready) core_q.push_back(core_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one beat and waits (bounded) for it to be accepted.
    task automatic send_beat(input logic [31:0] d, input logic last);
        logic ok;
        ok = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        for (int i = 0; i < 20; i++) begin
            if (s_tready === 1'b1) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("beat_accept", {31'h0, ok}, 32'h1);
    endtask

    task automatic do_start(input logic [15:0] rl, input logic [15:0] ql);
        start   = 1'b1;
        ref_len = rl;
        qry_len = ql;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        ref_len = 16'h0; qry_len = 16'h0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 32'h0;
        core_ready = 1'b1; core_done = 1'b0; core_score = 32'h0;
        m_tready = 1'b1;

        // Reset state
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_ref_valid", {31'h0, ref_valid}, 32'h0);
        check("rst_tready", {31'h0, s_tready}, 32'h0);
        check("rst_m_tvalid", {31'h0, m_tvalid}, 32'h0);
        check("rst_cycle", cycle_cnt, 32'h0);

        // Test 1: load 4 reference samples, 3 query samples, score 0x2A
        base_wr = wr_addr_q.size(); base_core = core_q.size(); base_cs = core_start_cnt;
        do_start(16'd4, 16'd3);
        check("t1_tready_after_start", {31'h0, s_tready}, 32'h1);
        check("t1_busy", {31'h0, busy}, 32'h1);
        check("t1_ref_valid_cleared", {31'h0, ref_valid}, 32'h0);
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b0);
        send_beat(32'd3, 1'b0);
        send_beat(32'd4, 1'b1);
        check("t1_core_start", {31'h0, core_start}, 32'h1);
        send_beat(32'd5, 1'b0);
        send_beat(32'd6, 1'b0);
        send_beat(32'd7, 1'b1);
        check("t1_wait_tready", {31'h0, s_tready}, 32'h0);
        core_done = 1'b1; core_score = 32'h2A;
        tick();
        core_done = 1'b0; core_score = 32'h0;
        check("t1_m_tvalid", {31'h0, m_tvalid}, 32'h1);
        check("t1_m_tlast", {31'h0, m_tlast}, 32'h1);
        check("t1_m_tdata", m_tdata, 32'h2A);
        check("t1_done_before_hs", {31'h0, done}, 32'h0);
        tick();
        check("t1_done", {31'h0, done}, 32'h1);
        check("t1_idle", {31'h0, busy}, 32'h0);
        check("t1_ref_valid", {31'h0, ref_valid}, 32'h1);
        check("t1_m_tvalid_off", {31'h0, m_tvalid}, 32'h0);
        check("t1_nwr", wr_addr_q.size() - base_wr, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base_wr + i < wr_addr_q.size()) begin
                check("t1_wr_addr", {16'h0, wr_addr_q[base_wr + i]}, i);
                check("t1_wr_data", wr_data_q[base_wr + i], i + 1);
            end else begin
                check("t1_wr_missing", 32'h0, 32'h1);
            end
        end
        check("t1_ncore_start", core_start_cnt - base_cs, 32'd1);
        check("t1_ncore", core_q.size() - base_core, 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (base_core + i < core_q.size())
                check("t1_core_data", core_q[base_core + i], i + 5);
            else
                check("t1_core_missing", 32'h0, 32'h1);
        end
`ifdef DTW_SEQ_CYCLE_CNT_EN
        check("t6_cycle_cnt", cycle_cnt, 32'd9);
`else
        check("t6_cycle_cnt_off", cycle_cnt, 32'd0);
`endif

        // Rejected start (qry_len 0): err set, done kept, counter held
        do_start(16'd4, 16'd0);
        check("rej_err", {31'h0, err}, 32'h1);
        check("rej_busy", {31'h0, busy}, 32'h0);
        check("rej_done_kept", {31'h0, done}, 32'h1);
`ifdef DTW_SEQ_CYCLE_CNT_EN
        check("rej_cycle_hold", cycle_cnt, 32'd9);
`else
        check("rej_cycle_off", cycle_cnt, 32'd0);
`endif

        // Stray core_done in IDLE is ignored
        core_done = 1'b1; core_score = 32'h55;
        tick();
        core_done = 1'b0;
        check("idle_done_ignored", {31'h0, m_tvalid}, 32'h0);
        check("idle_done_busy", {31'h0, busy}, 32'h0);

        // Test 2 + 4: reuse reference, result backpressured 5 cycles
        base_wr = wr_addr_q.size(); base_core = core_q.size(); base_cs = core_start_cnt;
        m_tready = 1'b0;
        do_start(16'd0, 16'd3);
        check("t2_core_start", {31'h0, core_start}, 32'h1);
        check("t2_err_cleared", {31'h0, err}, 32'h0);
        check("t2_done_cleared", {31'h0, done}, 32'h0);
        send_beat(32'd5, 1'b0);
        check("t2_core_start_pulse", {31'h0, core_start}, 32'h0);
        send_beat(32'd6, 1'b0);
        send_beat(32'd7, 1'b1);
        core_done = 1'b1; core_score = 32'h2A;
        tick();
        core_done = 1'b0; core_score = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check("t4_tvalid_hold", {31'h0, m_tvalid}, 32'h1);
            check("t4_tdata_hold", m_tdata, 32'h2A);
            check("t4_done_low", {31'h0, done}, 32'h0);
            tick();
        end
        m_tready = 1'b1;
        check("t4_tvalid_at_hs", {31'h0, m_tvalid}, 32'h1);
        tick();
        check("t4_done", {31'h0, done}, 32'h1);
        check("t4_idle", {31'h0, busy}, 32'h0);
        check("t2_nwr", wr_addr_q.size() - base_wr, 32'd0);
        check("t2_ncore_start", core_start_cnt - base_cs, 32'd1);
        check("t2_ncore", core_q.size() - base_core, 32'd3);
        if (base_core + 2 < core_q.size())
            check("t2_core_last", core_q[base_core + 2], 32'd7);
        else
            check("t2_core_missing", 32'h0, 32'h1);
`ifdef DTW_SEQ_CYCLE_CNT_EN
        check("t2_cycle_cnt", cycle_cnt, 32'd10);
`endif

        // Test 3: early tlast on the second reference beat
        do_start(16'd4, 16'd3);
        send_beat(32'h11, 1'b0);
        send_beat(32'h12, 1'b1);
        check("t3_err", {31'h0, err}, 32'h1);
        check("t3_idle", {31'h0, busy}, 32'h0);
        check("t3_ref_valid", {31'h0, ref_valid}, 32'h0);
        check("t3_tready", {31'h0, s_tready}, 32'h0);
        do_start(16'd0, 16'd3);
        check("t3_reuse_rej_busy", {31'h0, busy}, 32'h0);
        check("t3_reuse_rej_err", {31'h0, err}, 32'h1);
        check("t3_reuse_rej_cs", {31'h0, core_start}, 32'h0);

        // Test 5: abort on the 2nd query beat together with a start
        do_start(16'd2, 16'd3);
        check("t5_err_cleared", {31'h0, err}, 32'h0);
        send_beat(32'hA, 1'b0);
        send_beat(32'hB, 1'b1);
        send_beat(32'hC, 1'b0);
        s_tvalid = 1'b1; s_tdata = 32'hD;
        abort = 1'b1; start = 1'b1; ref_len = 16'd0; qry_len = 16'd3;
        tick();
        abort = 1'b0; start = 1'b0; s_tvalid = 1'b0;
        check("t5_idle", {31'h0, busy}, 32'h0);
        check("t5_tready", {31'h0, s_tready}, 32'h0);
        check("t5_done_kept", {31'h0, done}, 32'h0);
        check("t5_err_kept", {31'h0, err}, 32'h0);
        check("t5_ref_valid_kept", {31'h0, ref_valid}, 32'h1);
        check("t5_no_core_start", {31'h0, core_start}, 32'h0);
        core_done = 1'b1; core_score = 32'h77;
        tick();
        core_done = 1'b0;
        check("t5_start_ignored", {31'h0, busy}, 32'h0);
        check("t5_no_result", {31'h0, m_tvalid}, 32'h0);

        // Abort during reference load leaves the reference invalid
        do_start(16'd4, 16'd3);
        send_beat(32'h21, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_ld_idle", {31'h0, busy}, 32'h0);
        check("ab_ld_ref_valid", {31'h0, ref_valid}, 32'h0);
        check("ab_ld_err_kept", {31'h0, err}, 32'h0);

        // Reset mid-operation returns everything to reset values
        do_start(16'd0, 16'd0);
        do_start(16'd2, 16'd2);
        check("mid_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_err", {31'h0, err}, 32'h0);
        check("mid_rst_tready", {31'h0, s_tready}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_ref_valid", {31'h0, ref_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
